// File: rtl/quake_sample_sequencer.sv
// rtl/quake_sample_sequencer.sv - per-period 3-axis sample sequencer with threshold debounce and earthquake alarm
// Optional sticky alarm cleared by i_alarm_clr: define ALARM_LATCH_EN.
module quake_sample_sequencer #(
  parameter int unsigned SAMPLE_DIV   = 100000,
  parameter int unsigned SCALER_LAT   = 2,
  parameter int unsigned RD_TIMEOUT   = 1024,
  parameter logic [23:0] THRESH       = 24'd1000,
  parameter int unsigned TRIG_COUNT   = 3,
  parameter int unsigned HOLD_SAMPLES = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_en,
  output logic        o_rd_req,
  input  logic        i_rd_done,
  input  logic [15:0] i_xdata,
  input  logic [15:0] i_ydata,
  input  logic [15:0] i_zdata,
  output logic [15:0] o_xraw,
  output logic [15:0] o_yraw,
  output logic [15:0] o_zraw,
  input  logic [23:0] i_xs,
  input  logic [23:0] i_ys,
  input  logic [23:0] i_zs,
  output logic        o_sample_valid,
  output logic        o_exceed,
  output logic        o_alarm,
  input  logic        i_alarm_clr,
  output logic        o_rd_err,
  output logic        o_overrun
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TMO_W  = $clog2(RD_TIMEOUT + 1);
  localparam int LAT_W  = $clog2(SCALER_LAT + 1);
  localparam int TRIG_W = $clog2(TRIG_COUNT + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(RD_TIMEOUT - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(SCALER_LAT - 1);
  localparam logic [TRIG_W-1:0] TRIG_MAX = TRIG_W'(TRIG_COUNT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_EVAL = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [15:0]       xraw_q, xraw_d, yraw_q, yraw_d, zraw_q, zraw_d;
  logic              exceed_q, exceed_d;
  logic              alarm_q, alarm_d;
  logic              rd_err_q, rd_err_d;
  logic              overrun_q, overrun_d;
  logic              tick;
  logic              ex;

`ifndef ALARM_LATCH_EN
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_SAMPLES);
  logic [HOLD_W-1:0] quiet_cnt_q, quiet_cnt_d;
  logic              unused_clr;
  assign unused_clr = i_alarm_clr;
`endif

  always_comb begin
    tick        = i_en && (div_cnt_q == DIV_LAST);
    div_cnt_d   = (!i_en || tick) ? '0 : div_cnt_q + 1'b1;
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    trig_cnt_d  = trig_cnt_q;
    xraw_d      = xraw_q;
    yraw_d      = yraw_q;
    zraw_d      = zraw_q;
    exceed_d    = exceed_q;
    alarm_d     = alarm_q;
    rd_err_d    = 1'b0;
    overrun_d   = tick && (state_q != S_IDLE);
    ex          = (i_xs > THRESH) | (i_ys > THRESH) | (i_zs > THRESH);
`ifndef ALARM_LATCH_EN
    quiet_cnt_d = quiet_cnt_q;
`else
    // Clear is applied first so a same-cycle set in EVAL overrides it.
    if (i_alarm_clr) alarm_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d   = S_REQ;
          tmo_cnt_d = '0;
        end
      end
      S_REQ: begin
        if (i_rd_done) begin
          xraw_d    = i_xdata;
          yraw_d    = i_ydata;
          zraw_d    = i_zdata;
          lat_cnt_d = '0;
          state_d   = S_WAIT;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rd_err_d  = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == LAT_LAST) state_d = S_EVAL;
        else lat_cnt_d = lat_cnt_q + 1'b1;
      end
      S_EVAL: begin
        exceed_d = ex;
        state_d  = S_IDLE;
        if (ex) begin
          trig_cnt_d = (trig_cnt_q == TRIG_MAX) ? trig_cnt_q : trig_cnt_q + 1'b1;
          if (trig_cnt_d == TRIG_MAX) alarm_d = 1'b1;
`ifndef ALARM_LATCH_EN
          quiet_cnt_d = '0;
`endif
        end else begin
          trig_cnt_d = '0;
`ifndef ALARM_LATCH_EN
          quiet_cnt_d = (quiet_cnt_q == HOLD_MAX) ? quiet_cnt_q : quiet_cnt_q + 1'b1;
          if (quiet_cnt_d == HOLD_MAX) alarm_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      trig_cnt_q  <= '0;
      xraw_q      <= '0;
      yraw_q      <= '0;
      zraw_q      <= '0;
      exceed_q    <= 1'b0;
      alarm_q     <= 1'b0;
      rd_err_q    <= 1'b0;
      overrun_q   <= 1'b0;
`ifndef ALARM_LATCH_EN
      quiet_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      trig_cnt_q  <= trig_cnt_d;
      xraw_q      <= xraw_d;
      yraw_q      <= yraw_d;
      zraw_q      <= zraw_d;
      exceed_q    <= exceed_d;
      alarm_q     <= alarm_d;
      rd_err_q    <= rd_err_d;
      overrun_q   <= overrun_d;
`ifndef ALARM_LATCH_EN
      quiet_cnt_q <= quiet_cnt_d;
`endif
    end
  end

  assign o_rd_req       = (state_q == S_REQ);
  assign o_sample_valid = (state_q == S_EVAL);
  assign o_xraw         = xraw_q;
  assign o_yraw         = yraw_q;
  assign o_zraw         = zraw_q;
  assign o_exceed       = exceed_q;
  assign o_alarm        = alarm_q;
  assign o_rd_err       = rd_err_q;
  assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_quake_sample_sequencer.sv
// tb/tb_quake_sample_sequencer.sv - scoreboard bench: 2-cycle scaler model, sensor readers, debounce model
module tb_quake_sample_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rstn, rstn_b, en, clr;
  logic        rd_done, rd_done_b;
  logic [15:0] xdata, ydata, zdata;
  logic        rd_req, sample_valid, exceed, alarm, rd_err, overrun;
  logic [15:0] xraw, yraw, zraw;
  logic        rd_req_b, sample_valid_b, exceed_b, alarm_b, rd_err_b, overrun_b;
  logic [15:0] xraw_b, yraw_b, zraw_b;
  logic [15:0] s1x, s1y, s1z;
  logic [23:0] xs, ys, zs;

  quake_sample_sequencer #(.SAMPLE_DIV(16), .SCALER_LAT(2), .RD_TIMEOUT(8), .THRESH(24'd1000),
                           .TRIG_COUNT(3), .HOLD_SAMPLES(2)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .o_rd_req(rd_req), .i_rd_done(rd_done),
    .i_xdata(xdata), .i_ydata(ydata), .i_zdata(zdata),
    .o_xraw(xraw), .o_yraw(yraw), .o_zraw(zraw), .i_xs(xs), .i_ys(ys), .i_zs(zs),
    .o_sample_valid(sample_valid), .o_exceed(exceed), .o_alarm(alarm), .i_alarm_clr(clr),
    .o_rd_err(rd_err), .o_overrun(overrun));

  quake_sample_sequencer #(.SAMPLE_DIV(16), .SCALER_LAT(2), .RD_TIMEOUT(32), .THRESH(24'd1000),
                           .TRIG_COUNT(3), .HOLD_SAMPLES(2)) dut_b (
    .i_clk(clk), .i_rstn(rstn_b), .i_en(en), .o_rd_req(rd_req_b), .i_rd_done(rd_done_b),
    .i_xdata(xdata), .i_ydata(ydata), .i_zdata(zdata),
    .o_xraw(xraw_b), .o_yraw(yraw_b), .o_zraw(zraw_b), .i_xs(xs), .i_ys(ys), .i_zs(zs),
    .o_sample_valid(sample_valid_b), .o_exceed(exceed_b), .o_alarm(alarm_b), .i_alarm_clr(clr),
    .o_rd_err(rd_err_b), .o_overrun(overrun_b));

  // Scaler stand-in: identity scaling with two register stages.
  always @(posedge clk) begin
    s1x <= xraw; s1y <= yraw; s1z <= zraw;
    xs <= {8'h0, s1x}; ys <= {8'h0, s1y}; zs <= {8'h0, s1z};
  end

  int n_checks = 0;
  int n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {logic [15:0] x, y, z;} samp_t;
  samp_t stim_q[$];
  samp_t sb_q[$];
  int    done_cyc_q[$];
  int    delay_a = 2;
  logic [15:0] last_x = 16'h0;
  int    n_evals = 0;
  int    trig_m = 0, quiet_m = 0;
  logic  alarm_m = 1'b0;
  int    rd_err_cnt = 0, overrun_cnt = 0;

  // Reader for the main instance: answers after delay_a cycles, or never when delay_a is 0.
  initial begin : reader_a
    samp_t s;
    rd_done = 1'b0; xdata = '0; ydata = '0; zdata = '0;
    forever begin
      @(negedge clk);
      if (rstn && rd_req && delay_a > 0) begin
        repeat (delay_a) @(negedge clk);
        if (stim_q.size() != 0) s = stim_q.pop_front();
        else s = '{x: 16'd500, y: 16'd0, z: 16'd0};
        xdata = s.x; ydata = s.y; zdata = s.z; rd_done = 1'b1;
        last_x = s.x;
        sb_q.push_back(s);
        done_cyc_q.push_back(cyc);
        @(negedge clk);
        rd_done = 1'b0;
      end
    end
  end

  initial begin : reader_b
    rd_done_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn_b && rd_req_b) begin
        repeat (20) @(negedge clk);
        if (rstn_b && rd_req_b) begin
          rd_done_b = 1'b1;
          @(negedge clk);
          rd_done_b = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    samp_t e;
    int    dc;
    logic  ex;
    forever begin
      @(negedge clk);
      if (rstn && rd_err) rd_err_cnt++;
      if (rstn && overrun) overrun_cnt++;
      if (rstn && sample_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e  = sb_q.pop_front();
          dc = done_cyc_q.pop_front();
          check("done_to_valid", cyc - dc, 3);
          check("xs", xs, {8'h0, e.x});
          check("ys", ys, {8'h0, e.y});
          check("zs", zs, {8'h0, e.z});
          ex = (e.x > 16'd1000) || (e.y > 16'd1000) || (e.z > 16'd1000);
          if (ex) begin
            quiet_m = 0;
            trig_m  = (trig_m < 3) ? trig_m + 1 : 3;
            if (trig_m == 3) alarm_m = 1'b1;
          end else begin
            trig_m  = 0;
            quiet_m = (quiet_m < 2) ? quiet_m + 1 : 2;
`ifndef ALARM_LATCH_EN
            if (quiet_m == 2) alarm_m = 1'b0;
`endif
          end
          @(negedge clk);
          if (rd_err) rd_err_cnt++;
          check("valid_pulse", sample_valid, 1'b0);
          check("exceed", exceed, ex);
          check("alarm", alarm, alarm_m);
          n_evals++;
        end
      end
    end
  end

  int last_rise = -1;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (rd_req && !req_prev) begin
      if (last_rise >= 0) check("req_period", cyc - last_rise, 16);
      last_rise = cyc;
    end
    req_prev = rd_req;
  end

  task automatic add(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back('{x: x, y: y, z: z});
  endtask

  task automatic phase_a();
    int b, hc, ev0, n_stim;
    n_stim = stim_q.size();
    b = 0;
    while (n_evals < n_stim && b < 3000) begin @(negedge clk); b++; end
    check("drain", n_evals >= n_stim, 1'b1);
    b = 0;
    while (!sample_valid && b < 40) begin @(negedge clk); b++; end
    repeat (2) @(negedge clk);
`ifdef ALARM_LATCH_EN
    check("alarm_latched", alarm, 1'b1);
`else
    check("alarm_quiet", alarm, 1'b0);
`endif
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    alarm_m = 1'b0;
    check("alarm_after_clr", alarm, 1'b0);
    // Read timeout: reader stays silent.
    delay_a = 0;
    b = 0;
    while (!rd_req && b < 40) begin @(negedge clk); b++; end
    check("req_seen", rd_req, 1'b1);
    hc = 0;
    while (rd_req && hc < 40) begin hc++; @(negedge clk); end
    check("req_len", hc, 8);
    check("rd_err_pulse", rd_err, 1'b1);
    check("raw_hold", xraw, last_x);
    delay_a = 2;
    @(negedge clk);
    check("rd_err_clear", rd_err, 1'b0);
    ev0 = n_evals;
    b = 0;
    while (n_evals == ev0 && b < 60) begin @(negedge clk); b++; end
    check("retry_eval", n_evals > ev0, 1'b1);
    check("rd_err_count", rd_err_cnt, 1);
    check("overrun_a", overrun_cnt, 0);
  endtask

  task automatic phase_b();
    int b;
    logic seen;
    seen = 1'b0; b = 0;
    while (!seen && b < 100) begin @(negedge clk); b++; if (overrun_b) seen = 1'b1; end
    check("overrun_b", seen, 1'b1);
    @(negedge clk);
    check("overrun_b_pulse", overrun_b, 1'b0);
    b = 0;
    while (!rd_req_b && b < 40) begin @(negedge clk); b++; end
    check("req_b_seen", rd_req_b, 1'b1);
    repeat (3) @(negedge clk);
    rstn_b = 1'b0;
    @(negedge clk);
    check("rst_b_req", rd_req_b, 1'b0);
    check("rst_b_xraw", xraw_b, 16'h0);
    check("rst_b_valid", sample_valid_b, 1'b0);
    check("rst_b_exceed", exceed_b, 1'b0);
    check("rst_b_alarm", alarm_b, 1'b0);
    check("rst_b_err", {rd_err_b, overrun_b}, 2'b00);
  endtask

  initial begin
    rstn = 1'b0; rstn_b = 1'b0; en = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", rd_req, 1'b0);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_exceed", exceed, 1'b0);
    check("rst_alarm", alarm, 1'b0);
    check("rst_err", {rd_err, overrun}, 2'b00);
    check("rst_raw", {xraw, yraw, zraw}, 48'h0);
    add(16'd500, 16'd0, 16'd0, 2);
    add(16'd1001, 16'd0, 16'd0, 3);
    add(16'd1000, 16'd1000, 16'd1000, 1);
    add(16'd500, 16'd0, 16'd0, 1);
    add(16'd1001, 16'd0, 16'd0, 1);
    add(16'd500, 16'd0, 16'd0, 1);
    add(16'd1001, 16'd0, 16'd0, 1);
    add(16'd500, 16'd0, 16'd0, 2);
    add(16'd500, 16'd0, 16'd1001, 1);
    add(16'd0, 16'hFFFF, 16'd0, 1);
    add(16'd500, 16'd0, 16'd0, 2);
    add(16'd1001, 16'd0, 16'd0, 3);
    add(16'd500, 16'd0, 16'd0, 5);
    rstn = 1'b1; rstn_b = 1'b1; en = 1'b1;
    fork
      phase_a();
      phase_b();
    join
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
